// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: 8-way round-robin arbiter with locking grants, registered mux select and data capture.
// Define MUX_SEL_ARBITER_BURST_LIMIT_EN to cap a contended grant at BURST_LEN cycles.
module mux_sel_arbiter #(
    parameter int BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] i,
    output logic [7:0] gnt,
    output logic [2:0] s,
    output logic       busy,
    output logic       y,
    output logic       y_vld
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     state;
    logic [2:0] ptr, base, off, pick;
    logic [7:0] others, rot;
    logic       rel, burst_hit;

    if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_len
        $error("BURST_LEN must be in 1..15");
    end

`ifdef MUX_SEL_ARBITER_BURST_LIMIT_EN
    logic [3:0] cnt;
    assign burst_hit = (cnt == 4'(BURST_LEN)) && |others;
`else
    assign burst_hit = 1'b0;
`endif

    // gnt is zero in IDLE, so others is the full request vector there
    assign others = req & ~gnt;
    assign rel    = (state == GRANT) && (!req[s] || burst_hit);
    assign base   = rel ? s + 3'd1 : ptr;
    assign rot    = 8'({others, others} >> base);
    assign pick   = base + off;

    always_comb begin
        off = '0;
        for (int k = 7; k >= 0; k--) if (rot[k]) off = 3'(k);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            s     <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
            y     <= 1'b0;
            y_vld <= 1'b0;
`ifdef MUX_SEL_ARBITER_BURST_LIMIT_EN
            cnt   <= '0;
`endif
        end else begin
            y     <= busy & i[s];
            y_vld <= busy;
            if (state == IDLE || rel) begin
                if (rel) ptr <= base;
                if (|others) begin
                    state <= GRANT;
                    s     <= pick;
                    gnt   <= 8'd1 << pick;
                    busy  <= 1'b1;
`ifdef MUX_SEL_ARBITER_BURST_LIMIT_EN
                    cnt   <= 4'd1;
`endif
                end else begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            end
`ifdef MUX_SEL_ARBITER_BURST_LIMIT_EN
            else if (cnt != 4'(BURST_LEN)) cnt <= cnt + 4'd1;
`endif
        end
    end
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: directed checks of mux_sel_arbiter; inputs driven and outputs sampled on falling edges.
module tb_mux_sel_arbiter;
    logic       clk, rst, busy, y, y_vld;
    logic [7:0] req, i, gnt;
    logic [2:0] s;
    int checks = 0, errors = 0;

    mux_sel_arbiter #(.BURST_LEN(4)) dut (
        .clk(clk), .rst(rst), .req(req), .i(i),
        .gnt(gnt), .s(s), .busy(busy), .y(y), .y_vld(y_vld)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1; req = 0; i = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; req = 8'hFF; i = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({gnt, s, busy, y, y_vld} !== 14'd0) begin
            errors++;
            $display("FAIL reset_hold got gnt=%h s=%0d busy=%b y=%b y_vld=%b exp all zero", gnt, s, busy, y, y_vld);
        end
        req = 0; i = 0; rst = 0;
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h08; i = 8'h08;
        @(negedge clk);
        checks++;
        if ({gnt, s, busy, y_vld} !== {8'h08, 3'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_grant got gnt=%h s=%0d busy=%b y_vld=%b exp 08 3 1 0", gnt, s, busy, y_vld);
        end
        @(negedge clk);
        checks++;
        if ({y, y_vld} !== 2'b11) begin
            errors++;
            $display("FAIL single_data got y=%b y_vld=%b exp 1 1", y, y_vld);
        end
        req = 0;
        @(negedge clk);
        checks++;
        if ({gnt, s, busy} !== {8'h00, 3'd3, 1'b0}) begin
            errors++;
            $display("FAIL single_idle got gnt=%h s=%0d busy=%b exp 00 3 0", gnt, s, busy);
        end
        @(negedge clk);
        checks++;
        if ({y, y_vld, s} !== {2'b00, 3'd3}) begin
            errors++;
            $display("FAIL single_idle_hold got y=%b y_vld=%b s=%0d exp 0 0 3", y, y_vld, s);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 8'hFF;
        @(negedge clk);
        req = 8'hFE;
        @(negedge clk);
        checks++;
        if ({gnt, s, busy} !== {8'h02, 3'd1, 1'b1}) begin
            errors++;
            $display("FAIL mid_pre got gnt=%h s=%0d busy=%b exp 02 1 1", gnt, s, busy);
        end
        req = 8'hFF;
        #2 rst = 1;
        #1;
        checks++;
        if ({gnt, s, busy, y, y_vld} !== 14'd0) begin
            errors++;
            $display("FAIL mid_async got gnt=%h s=%0d busy=%b y=%b y_vld=%b exp all zero", gnt, s, busy, y, y_vld);
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        checks++;
        if ({gnt, s, busy} !== {8'h01, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL mid_ptr_reset got gnt=%h s=%0d busy=%b exp 01 0 1", gnt, s, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_s [5] = '{3'd1, 3'd3, 3'd6, 3'd7, 3'd1};
        logic [7:0] g;
        do_reset();
        req = 8'hCA;
        for (int j = 0; j < 5; j++) begin
            g = 8'd1 << exp_s[j];
            @(negedge clk);
            checks++;
            if ({gnt, s, busy} !== {g, exp_s[j], 1'b1}) begin
                errors++;
                $display("FAIL rr_grant%0d got gnt=%h s=%0d busy=%b exp %h %0d 1", j, gnt, s, busy, g, exp_s[j]);
            end
            req = 8'hCA;
            @(negedge clk);
            checks++;
            if (s !== exp_s[j]) begin
                errors++;
                $display("FAIL rr_hold%0d got s=%0d exp %0d", j, s, exp_s[j]);
            end
            req = 8'hCA & ~g;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 8'h40;
        @(negedge clk);
        checks++;
        if (s !== 3'd6) begin
            errors++;
            $display("FAIL wrap_pre got s=%0d exp 6", s);
        end
        req = 8'h81;
        @(negedge clk);
        checks++;
        if ({gnt, s} !== {8'h80, 3'd7}) begin
            errors++;
            $display("FAIL wrap_7 got gnt=%h s=%0d exp 80 7", gnt, s);
        end
        req = 8'h01;
        @(negedge clk);
        checks++;
        if ({gnt, s, busy} !== {8'h01, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL wrap_0 got gnt=%h s=%0d busy=%b exp 01 0 1", gnt, s, busy);
        end
    endtask

    task automatic test_burst();
        logic [2:0] e;
        do_reset();
        req = 8'h03;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
`ifdef MUX_SEL_ARBITER_BURST_LIMIT_EN
            e = 3'(((k - 1) / 4) % 2);
`else
            e = 3'd0;
`endif
            checks++;
            if ({s, busy} !== {e, 1'b1}) begin
                errors++;
                $display("FAIL burst_cyc%0d got s=%0d busy=%b exp %0d 1", k, s, busy, e);
            end
        end
    endtask

    task automatic test_data();
        logic e;
        do_reset();
        req = 8'h04; i = 8'h0F;
        @(negedge clk);
        checks++;
        if ({s, y_vld} !== {3'd2, 1'b0}) begin
            errors++;
            $display("FAIL data_grant got s=%0d y_vld=%b exp 2 0", s, y_vld);
        end
        for (int j = 0; j < 6; j++) begin
            i = (j % 2 == 1) ? 8'h5A : 8'h0F;
            e = (j % 2 == 0);
            @(negedge clk);
            checks++;
            if ({y, y_vld} !== {e, 1'b1}) begin
                errors++;
                $display("FAIL data_y%0d got y=%b y_vld=%b exp %b 1", j, y, y_vld, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid_grant();
        test_round_robin();
        test_wrap();
        test_burst();
        test_data();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
